// File: rtl/uart_tx_fifo.sv
// Byte FIFO that drains into the UART wrapper through its tx_wr/tx_flag handshake.
// Define UART_TX_CRLF_EN to expand each stored 8'h0A into the pair 8'h0D, 8'h0A on the wire.
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic [7:0]            tx_data,
   output logic                  tx_wr,
   input  logic                  tx_flag
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wrPtr_q;
   logic [DEPTH_LOG2-1:0] rdPtr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic [DEPTH_LOG2:0]   count_d;
   logic                  full_q;
   logic                  empty_q;
   logic                  overflow_q;
   state_t                state_q;
   logic [7:0]            txData_q;
   logic                  txWr_q;
   logic [7:0]            headByte;
   logic                  wrAccept;
   logic                  loadDo;
   logic                  crInsert;
   logic                  popDo;
`ifdef UART_TX_CRLF_EN
   logic                  crDone_q;
`endif

   assign headByte = mem_q[rdPtr_q];

   // full is the registered flag, so a pop in the same cycle never frees room for a write
   always_comb begin
      wrAccept = wr_en && !full_q;
      loadDo   = (state_q == IDLE) && !empty_q && tx_flag;
`ifdef UART_TX_CRLF_EN
      crInsert = loadDo && (headByte == 8'h0A) && !crDone_q;
`else
      crInsert = 1'b0;
`endif
      popDo    = loadDo && !crInsert;
      count_d  = count_q;
      if (wrAccept && !popDo) begin
         count_d = count_q + CNT_ONE;
      end else if (!wrAccept && popDo) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wrAccept) begin
         mem_q[wrPtr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (wrAccept) begin
            wrPtr_q <= wrPtr_q + PTR_ONE;
         end
         if (popDo) begin
            rdPtr_q <= rdPtr_q + PTR_ONE;
         end
         if (wr_en && full_q) begin
            overflow_q <= 1'b1;
         end
         count_q <= count_d;
         full_q  <= (count_d == CNT_FULL);
         empty_q <= (count_d == '0);
      end
   end

   // Drain FSM: one frame per byte, paced by the wrapper dropping and raising tx_flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         txData_q <= 8'h00;
         txWr_q   <= 1'b0;
`ifdef UART_TX_CRLF_EN
         crDone_q <= 1'b0;
`endif
      end else begin
         txWr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (loadDo) begin
                  txWr_q  <= 1'b1;
                  state_q <= ISSUE;
                  if (crInsert) begin
                     txData_q <= 8'h0D;
                  end else begin
                     txData_q <= headByte;
                  end
`ifdef UART_TX_CRLF_EN
                  crDone_q <= crInsert;
`endif
               end
            end
            ISSUE: begin
               state_q <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (!tx_flag) begin
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (tx_flag) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign tx_data  = txData_q;
   assign tx_wr    = txWr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: cycle vector table plus a UART wrapper model feeding a byte scoreboard.
// Also builds with UART_TX_CRLF_EN defined, which changes the expected newline expansion.
module tb_uart_tx_fifo;

   localparam int FRAME_CYCLES = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] wrData;
   logic       wrEn;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic [7:0] txData;
   logic       txWr;
   logic       txFlag;
   logic       tbFlag = 1'b1;
   logic       modelFlag = 1'b1;
   logic       modelEn = 1'b0;

   int         vecCount = 0;
   int         missCount = 0;
   int         busyCnt = 0;
   int         rxCount = 0;
   logic       prevTxWr = 1'b0;
   logic [7:0] expQ[$];

   typedef struct {
      logic       wrEn;
      logic [7:0] wrData;
      logic       txFlag;
      logic       expTxWr;
      logic [7:0] expTxData;
      logic [4:0] expCount;
      logic       expEmpty;
      logic       expFull;
      logic       expOverflow;
   } vec_t;

   vec_t vecs[11];

   always #5 clk = ~clk;

   assign txFlag = modelEn ? modelFlag : tbFlag;

   uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
      .clk(clk),
      .reset(reset),
      .wr_data(wrData),
      .wr_en(wrEn),
      .full(full),
      .empty(empty),
      .count(count),
      .overflow(overflow),
      .tx_data(txData),
      .tx_wr(txWr),
      .tx_flag(txFlag)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Wrapper model: a tx_wr pulse takes the wrapper busy for one frame, and the byte is scored
   always @(negedge clk) begin
      if (!modelEn) begin
         busyCnt   = 0;
         modelFlag = 1'b1;
      end else if (txWr) begin
         checkOutput("tx_wr single cycle", 32'(prevTxWr), 32'd0);
         checkOutput("tx_flag high before tx_wr", 32'(modelFlag), 32'd1);
         if (expQ.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL unexpected tx byte: got %0h, expected none", txData);
         end else begin
            checkOutput("tx byte order", 32'(txData), 32'(expQ.pop_front()));
         end
         rxCount++;
         modelFlag = 1'b0;
         busyCnt   = FRAME_CYCLES;
      end else if (busyCnt > 0) begin
         busyCnt--;
         if (busyCnt == 0) begin
            modelFlag = 1'b1;
         end
      end
      prevTxWr = txWr;
   end

   task automatic applyStimulus(input vec_t v, input int idx);
      wrEn   = v.wrEn;
      wrData = v.wrData;
      tbFlag = v.txFlag;
      @(negedge clk);
      checkOutput($sformatf("vector %0d {tx_wr,tx_data,count,empty,full,overflow}", idx),
                  32'({txWr, txData, count, empty, full, overflow}),
                  32'({v.expTxWr, v.expTxData, v.expCount, v.expEmpty, v.expFull, v.expOverflow}));
   endtask

   task automatic writeByte(input logic [7:0] d, input bit push);
      wrEn   = 1'b1;
      wrData = d;
      if (push) expQ.push_back(d);
      @(negedge clk);
      wrEn = 1'b0;
   endtask

   task automatic doReset();
      reset   = 1'b1;
      wrEn    = 1'b0;
      wrData  = 8'h00;
      modelEn = 1'b0;
      tbFlag  = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic waitDrain(input int bound);
      for (int c = 0; c < bound; c++) begin
         if (expQ.size() == 0 && busyCnt == 0 && modelFlag && empty) break;
         @(negedge clk);
      end
      @(negedge clk);
      checkOutput("drain complete (bytes left)", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      // Fields: wrEn, wrData, txFlag | tx_wr, tx_data, count, empty, full, overflow
      vecs[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h42, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 5'd0, 1'b1, 1'b0, 1'b0};

      doReset();
      reset = 1'b1;
      @(negedge clk);
      checkOutput("reset state {tx_wr,tx_data,count,empty,full,overflow}",
                  32'({txWr, txData, count, empty, full, overflow}),
                  32'({1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0}));
      reset = 1'b0;

      // Single byte latency and handshake walk-through
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Burst of 16 bytes drained by the wrapper model
      begin
         int rxStart;
         rxStart = rxCount;
         modelEn = 1'b1;
         for (int i = 0; i < 16; i++) writeByte(8'(i), 1'b1);
         waitDrain(1000);
         checkOutput("burst tx count", 32'(rxCount - rxStart), 32'd16);
         checkOutput("burst overflow", 32'(overflow), 32'd0);
      end

      // Fill with wrapper busy, 17th write dropped, then drain
      begin
         int rxStart;
         modelEn = 1'b0;
         tbFlag  = 1'b0;
         for (int i = 0; i < 17; i++) begin
            writeByte(8'h20 + 8'(i), i < 16);
            if (i == 15) begin
               checkOutput("full after 16", 32'({full, count}), 32'({1'b1, 5'd16}));
               checkOutput("no overflow at 16", 32'(overflow), 32'd0);
            end
         end
         checkOutput("17th dropped {overflow,count}", 32'({overflow, count}), 32'({1'b1, 5'd16}));
         rxStart = rxCount;
         modelEn = 1'b1;
         waitDrain(1000);
         checkOutput("full drain tx count", 32'(rxCount - rxStart), 32'd16);
         checkOutput("overflow sticky after drain", 32'({overflow, count, empty}), 32'({1'b1, 5'd0, 1'b1}));
      end

      // Write on the same cycle as a pop from a full FIFO is dropped
      doReset();
      tbFlag = 1'b0;
      for (int i = 0; i < 16; i++) writeByte(8'h80 + 8'(i), 1'b1);
      checkOutput("full before pop", 32'(full), 32'd1);
      wrEn   = 1'b1;
      wrData = 8'hAA;
      tbFlag = 1'b1;
      @(negedge clk);
      checkOutput("pop+write {count,full,overflow,tx_wr}", 32'({count, full, overflow, txWr}),
                  32'({5'd15, 1'b0, 1'b1, 1'b1}));
      checkOutput("pop byte", 32'(txData), 32'(expQ.pop_front()));
      wrData = 8'hBB;
      tbFlag = 1'b0;
      expQ.push_back(8'hBB);
      @(negedge clk);
      wrEn = 1'b0;
      checkOutput("write after pop {count,full}", 32'({count, full}), 32'({5'd16, 1'b1}));
      @(negedge clk);
      modelEn = 1'b1;
      waitDrain(1000);
      checkOutput("after drain count", 32'(count), 32'd0);

      // Reset while waiting for the frame to finish with 5 bytes queued
      doReset();
      checkOutput("reset clears overflow", 32'(overflow), 32'd0);
      tbFlag = 1'b0;
      for (int i = 0; i < 6; i++) writeByte(8'h60 + 8'(i), 1'b0);
      tbFlag = 1'b1;
      @(negedge clk);
      tbFlag = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("queued before reset", 32'(count), 32'd5);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid-frame reset {tx_wr,tx_data,count,empty,full,overflow}",
                  32'({txWr, txData, count, empty, full, overflow}),
                  32'({1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0}));
      reset  = 1'b0;
      tbFlag = 1'b1;
      begin
         int pulses;
         pulses = 0;
         repeat (40) begin
            @(negedge clk);
            if (txWr) pulses++;
         end
         checkOutput("no tx_wr after reset", 32'(pulses), 32'd0);
      end

      // Newline handling
      doReset();
      modelEn = 1'b1;
      begin
         int rxStart;
         rxStart = rxCount;
         writeByte(8'h41, 1'b1);
`ifdef UART_TX_CRLF_EN
         expQ.push_back(8'h0D);
`endif
         writeByte(8'h0A, 1'b1);
         writeByte(8'h42, 1'b1);
         waitDrain(1000);
`ifdef UART_TX_CRLF_EN
         checkOutput("newline tx count", 32'(rxCount - rxStart), 32'd4);
`else
         checkOutput("newline tx count", 32'(rxCount - rxStart), 32'd3);
`endif
         checkOutput("newline final count", 32'({count, empty}), 32'({5'd0, 1'b1}));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
